// File: rtl/tff_counter_n_if.sv
// Control/status bundle for tff_counter_n: counter controls in, count and flags out.
interface tff_counter_n_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, load, load_val, clr_ovf,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, load, load_val, clr_ovf,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/tff_counter_n.sv
// WIDTH-bit up/down counter built from per-bit toggle stages, with modulus,
// saturating parallel load, terminal-count flag, wrap pulse and sticky overflow.
module tff_counter_n #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1
) (
    input logic            sysclk,
    input logic            rst,
    tff_counter_n_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] tog;
    logic             tc;

    // Toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin : toggle_chain
        logic ones_below;
        logic zeros_below;
        tog         = '0;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            tog[i]      = bus.up_dn ? ones_below : zeros_below;
            ones_below  = ones_below & q_q[i];
            zeros_below = zeros_below & ~q_q[i];
        end
    end

    assign tc = bus.en & ((bus.up_dn & (q_q == MAX_V)) | (~bus.up_dn & (q_q == '0)));

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.load) begin
            q_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (bus.en) begin
            if (tc) begin
                q_d    = bus.up_dn ? '0 : MAX_V;
                wrap_d = 1'b1;
            end else begin
                q_d = q_q ^ tog;
            end
        end
        // Set dominates clear when both land on the same edge.
        if (bus.clr_ovf) ovf_d = 1'b0;
        if (wrap_d)      ovf_d = 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_tff_counter_n.sv
// Self-checking bench for tff_counter_n (WIDTH=4, MAX_COUNT=9) against an arithmetic model.
module tb_tff_counter_n;

    localparam int unsigned W   = 4;
    localparam int unsigned MAX = 9;

    logic sysclk = 1'b0;
    logic rst;

    tff_counter_n_if #(.WIDTH(W)) bus ();

    tff_counter_n #(.WIDTH(W), .MAX_COUNT(MAX)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 sysclk = ~sysclk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    int unsigned m_q    = 0;
    bit          m_wrap = 1'b0;
    bit          m_ovf  = 1'b0;

    function automatic bit exp_tc();
        if (!bus.en) return 1'b0;
        return bus.up_dn ? (m_q == MAX) : (m_q == 0);
    endfunction

    // Advance one edge, updating the model from the inputs presented at that edge.
    task automatic tick();
        int unsigned nq;
        bit          w;
        bit          o;
        nq = m_q;
        w  = 1'b0;
        o  = m_ovf;
        if (!rst) begin
            nq = 0;
            o  = 1'b0;
        end else begin
            if (bus.load) begin
                nq = (int'(bus.load_val) > MAX) ? MAX : int'(bus.load_val);
            end else if (bus.en) begin
                if (bus.up_dn) begin
                    if (m_q == MAX) begin nq = 0; w = 1'b1; end
                    else nq = m_q + 1;
                end else begin
                    if (m_q == 0) begin nq = MAX; w = 1'b1; end
                    else nq = m_q - 1;
                end
            end
            if (w) o = 1'b1;
            else if (bus.clr_ovf) o = 1'b0;
        end
        @(posedge sysclk);
        m_q    = nq;
        m_wrap = w;
        m_ovf  = o;
        #1;
    endtask

    task automatic idle_inputs();
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'd7;
        bus.clr_ovf  = 1'b0;
        bus.up_dn    = 1'($urandom_range(0, 1));
        tick();
        tick();
        vecs++; if (bus.q !== 4'd0) begin errs++; $display("FAIL reset_q: got %0d expected 0", bus.q); end
        vecs++; if (bus.wrap !== 1'b0) begin errs++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
        vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        vecs++; if (bus.tc !== ~bus.up_dn) begin errs++; $display("FAIL reset_tc: got %b expected %b", bus.tc, ~bus.up_dn); end
    endtask

    task automatic test_up_count();
        idle_inputs();
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.up_dn = 1'b1;
        #1;
        for (int i = 1; i <= 10; i++) begin
            vecs++; if (bus.tc !== (i == 10)) begin errs++; $display("FAIL up_tc step %0d: got %b expected %b", i, bus.tc, (i == 10)); end
            tick();
            vecs++; if (bus.q !== 4'(i % 10)) begin errs++; $display("FAIL up_q step %0d: got %0d expected %0d", i, bus.q, i % 10); end
            vecs++; if (bus.wrap !== (i == 10)) begin errs++; $display("FAIL up_wrap step %0d: got %b expected %b", i, bus.wrap, (i == 10)); end
            vecs++; if (bus.ovf !== (i == 10)) begin errs++; $display("FAIL up_ovf step %0d: got %b expected %b", i, bus.ovf, (i == 10)); end
        end
        tick();
        vecs++; if (bus.q !== 4'd1) begin errs++; $display("FAIL up_after_q: got %0d expected 1", bus.q); end
        vecs++; if (bus.wrap !== 1'b0) begin errs++; $display("FAIL up_wrap_pulse: got %b expected 0", bus.wrap); end
        vecs++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL up_ovf_sticky: got %b expected 1", bus.ovf); end
    endtask

    task automatic test_down_count();
        int unsigned exp_seq[4] = '{9, 8, 7, 6};
        idle_inputs();
        bus.load     = 1'b1;
        bus.load_val = 4'd0;
        tick();
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        bus.up_dn = 1'b0;
        #1;
        vecs++; if (bus.tc !== 1'b1) begin errs++; $display("FAIL down_tc_at0: got %b expected 1", bus.tc); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++; if (bus.q !== 4'(exp_seq[i])) begin errs++; $display("FAIL down_q %0d: got %0d expected %0d", i, bus.q, exp_seq[i]); end
            vecs++; if (bus.wrap !== (i == 0)) begin errs++; $display("FAIL down_wrap %0d: got %b expected %b", i, bus.wrap, (i == 0)); end
        end
        bus.up_dn = 1'b1;
        tick();
        vecs++; if (bus.q !== 4'd7) begin errs++; $display("FAIL dir_switch_q: got %0d expected 7", bus.q); end
    endtask

    task automatic test_load();
        bit ovf_before;
        idle_inputs();
        bus.load     = 1'b1;
        bus.load_val = 4'd12;
        tick();
        vecs++; if (bus.q !== 4'd9) begin errs++; $display("FAIL load_sat_q: got %0d expected 9", bus.q); end
        ovf_before   = m_ovf;
        bus.en       = 1'b1;
        bus.up_dn    = 1'b1;
        bus.load_val = 4'd3;
        tick();
        vecs++; if (bus.q !== 4'd3) begin errs++; $display("FAIL load_over_wrap_q: got %0d expected 3", bus.q); end
        vecs++; if (bus.wrap !== 1'b0) begin errs++; $display("FAIL load_wrap: got %b expected 0", bus.wrap); end
        vecs++; if (bus.ovf !== ovf_before) begin errs++; $display("FAIL load_ovf: got %b expected %b", bus.ovf, ovf_before); end
    endtask

    task automatic test_hold_sticky();
        logic [W-1:0] held;
        idle_inputs();
        held = bus.q;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++; if (bus.q !== held) begin errs++; $display("FAIL hold_q %0d: got %0d expected %0d", i, bus.q, held); end
            vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL hold_tc %0d: got %b expected 0", i, bus.tc); end
        end
        bus.clr_ovf = 1'b1;
        tick();
        vecs++; if (bus.ovf !== 1'b0) begin errs++; $display("FAIL clr_ovf: got %b expected 0", bus.ovf); end
        bus.clr_ovf  = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        tick();
        bus.load    = 1'b0;
        bus.en      = 1'b1;
        bus.clr_ovf = 1'b1;
        tick();
        vecs++; if (bus.ovf !== 1'b1) begin errs++; $display("FAIL clr_vs_wrap_ovf: got %b expected 1", bus.ovf); end
        vecs++; if (bus.wrap !== 1'b1) begin errs++; $display("FAIL clr_vs_wrap_wrap: got %b expected 1", bus.wrap); end
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.load     = 1'b1;
        bus.load_val = 4'd0;
        tick();
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vecs++; if (bus.q !== 4'd5) begin errs++; $display("FAIL mid_pre_q: got %0d expected 5", bus.q); end
        rst = 1'b0;
        tick();
        vecs++; if (bus.q !== 4'd0) begin errs++; $display("FAIL mid_rst_q: got %0d expected 0", bus.q); end
        vecs++; if (bus.wrap !== 1'b0) begin errs++; $display("FAIL mid_rst_wrap: got %b expected 0", bus.wrap); end
        rst = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            vecs++; if (bus.q !== 4'(i)) begin errs++; $display("FAIL mid_resume_q %0d: got %0d expected %0d", i, bus.q, i); end
        end
        // Reset while tc is high: no wrap pulse afterwards.
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        tick();
        bus.load = 1'b0;
        rst      = 1'b0;
        tick();
        vecs++; if (bus.wrap !== 1'b0) begin errs++; $display("FAIL rst_at_tc_wrap: got %b expected 0", bus.wrap); end
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 19) != 0);
            bus.en       = ($urandom_range(0, 3) != 0);
            bus.up_dn    = 1'($urandom_range(0, 1));
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.load_val = 4'($urandom_range(0, 15));
            bus.clr_ovf  = ($urandom_range(0, 5) == 0);
            #1;
            vecs++; if (bus.tc !== exp_tc()) begin errs++; $display("FAIL rand_tc %0d: got %b expected %b", n, bus.tc, exp_tc()); end
            tick();
            vecs++; if (bus.q !== 4'(m_q)) begin errs++; $display("FAIL rand_q %0d: got %0d expected %0d", n, bus.q, m_q); end
            vecs++; if (bus.wrap !== m_wrap) begin errs++; $display("FAIL rand_wrap %0d: got %b expected %b", n, bus.wrap, m_wrap); end
            vecs++; if (bus.ovf !== m_ovf) begin errs++; $display("FAIL rand_ovf %0d: got %b expected %b", n, bus.ovf, m_ovf); end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2;
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_hold_sticky();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
